bnn_feature_loader: RTL and testbench

Sequential front-end and result-capture stage for the combinational BNN classifiers such as `pendigits_bnn1_bnnpaar`. It accepts one `FEAT_BITS`-wide feature word per valid/ready beat and assembles the packed `features` bus the classifier consumes. It holds that bus stable for a programmable settle time, then samples the classifier's `prediction` and emits it on a valid/ready result port. It forms the producer/consumer end of the classifier's `features`/`prediction` interface.

---
 rtl/bnn_pkg.sv | 15 +
 rtl/bnn_feat_deser.sv | 36 +++
 rtl/bnn_feature_loader.sv | 108 ++++++++++
 tb/tb_bnn_feature_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared types, dataset defaults and helpers for the BNN classifier front-end.
package bnn_pkg;

  typedef enum logic [1:0] {StLoad, StSettle, StOut} loader_state_t;

  // pendigits dataset defaults
  localparam int unsigned PendigitsFeatCnt  = 16;
  localparam int unsigned PendigitsFeatBits = 4;
  localparam int unsigned PendigitsClassCnt = 10;

  function automatic int unsigned pred_bits(input int unsigned class_cnt);
    return (class_cnt > 1) ? $clog2(class_cnt) : 1;
  endfunction

endpackage

// File: rtl/bnn_feat_deser.sv
// Word-indexed deserializer: writes each accepted word into its slot of the packed feature bus.
module bnn_feat_deser import bnn_pkg::*; #(
  parameter int unsigned FEAT_CNT  = PendigitsFeatCnt,
  parameter int unsigned FEAT_BITS = PendigitsFeatBits
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [FEAT_BITS-1:0]          wr_data,
  output logic [FEAT_CNT*FEAT_BITS-1:0] features,
  output logic                          last_beat
);

  localparam int unsigned IdxBits = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam logic [IdxBits-1:0] IdxLast = IdxBits'(FEAT_CNT - 1);

  logic [IdxBits-1:0]            idx_q;
  logic [FEAT_CNT*FEAT_BITS-1:0] features_q;

  assign last_beat = wr_en && (idx_q == IdxLast);
  assign features  = features_q;

  // Slots are only ever overwritten, never cleared between vectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      features_q <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < FEAT_CNT; i++) begin
        if (idx_q == IdxBits'(i)) features_q[i*FEAT_BITS +: FEAT_BITS] <= wr_data;
      end
      idx_q <= last_beat ? '0 : idx_q + IdxBits'(1);
    end
  end

endmodule

// File: rtl/bnn_feature_loader.sv
// Feature loader / result capture around a combinational BNN classifier.
// Optional BNN_LOADER_STATS_EN adds label input and saturating total/correct counters.
module bnn_feature_loader import bnn_pkg::*; #(
  parameter int unsigned FEAT_CNT      = PendigitsFeatCnt,
  parameter int unsigned FEAT_BITS     = PendigitsFeatBits,
  parameter int unsigned CLASS_CNT     = PendigitsClassCnt,
  parameter int unsigned SETTLE_CYCLES = 2,
`ifdef BNN_LOADER_STATS_EN
  parameter int unsigned CNT_BITS      = 16,
`endif
  localparam int unsigned PRED_BITS    = pred_bits(CLASS_CNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [FEAT_BITS-1:0]          s_data,
  output logic [FEAT_CNT*FEAT_BITS-1:0] features,
  input  logic [PRED_BITS-1:0]          pred_in,
`ifdef BNN_LOADER_STATS_EN
  input  logic [PRED_BITS-1:0]          s_label,
  output logic [CNT_BITS-1:0]           total_cnt,
  output logic [CNT_BITS-1:0]           correct_cnt,
`endif
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [PRED_BITS-1:0]          m_pred
);

  localparam int unsigned SettleBits = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  loader_state_t         state_q;
  logic [SettleBits-1:0] settle_q;
  logic                  beat;
  logic                  last_beat;
  logic                  capture;

  assign s_ready = (state_q == StLoad);
  assign beat    = s_valid && s_ready;
  assign capture = (state_q == StSettle) && (settle_q == '0);

  bnn_feat_deser #(
    .FEAT_CNT  (FEAT_CNT),
    .FEAT_BITS (FEAT_BITS)
  ) u_deser (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (beat),
    .wr_data   (s_data),
    .features  (features),
    .last_beat (last_beat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StLoad;
      settle_q <= '0;
      m_valid  <= 1'b0;
      m_pred   <= '0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (last_beat) begin
            settle_q <= SettleBits'(SETTLE_CYCLES);
            state_q  <= StSettle;
          end
        end
        StSettle: begin
          if (capture) begin
            m_pred  <= pred_in;
            m_valid <= 1'b1;
            state_q <= StOut;
          end else begin
            settle_q <= settle_q - SettleBits'(1);
          end
        end
        StOut: begin
          if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            state_q <= StLoad;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

`ifdef BNN_LOADER_STATS_EN
  logic [PRED_BITS-1:0] label_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      label_q     <= '0;
      total_cnt   <= '0;
      correct_cnt <= '0;
    end else begin
      if (last_beat) label_q <= s_label;
      if (capture) begin
        if (total_cnt != '1) total_cnt <= total_cnt + CNT_BITS'(1);
        if ((pred_in == label_q) && (correct_cnt != '1)) begin
          correct_cnt <= correct_cnt + CNT_BITS'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_bnn_feature_loader.sv
// Directed self-checking bench for bnn_feature_loader (settle=2 and settle=0 instances).
module tb_bnn_feature_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b1;
  logic [3:0]  s_data = '0, pred_in = '0, m_pred;
  logic [63:0] features;

  logic        z_s_valid = 1'b0, z_s_ready, z_m_valid, z_m_ready = 1'b1;
  logic [3:0]  z_s_data = '0, z_pred_in = '0, z_m_pred;
  logic [63:0] z_features;

`ifdef BNN_LOADER_STATS_EN
  logic [3:0]  s_label = '0, z_s_label = '0;
  logic [15:0] total_cnt, correct_cnt;
  logic [1:0]  z_total_cnt, z_correct_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  always #5 clk = ~clk;

  bnn_feature_loader #(
    .SETTLE_CYCLES (2)
`ifdef BNN_LOADER_STATS_EN
    , .CNT_BITS    (16)
`endif
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .features    (features),
    .pred_in     (pred_in),
`ifdef BNN_LOADER_STATS_EN
    .s_label     (s_label),
    .total_cnt   (total_cnt),
    .correct_cnt (correct_cnt),
`endif
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_pred      (m_pred)
  );

  bnn_feature_loader #(
    .SETTLE_CYCLES (0)
`ifdef BNN_LOADER_STATS_EN
    , .CNT_BITS    (2)
`endif
  ) u_dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (z_s_valid),
    .s_ready     (z_s_ready),
    .s_data      (z_s_data),
    .features    (z_features),
    .pred_in     (z_pred_in),
`ifdef BNN_LOADER_STATS_EN
    .s_label     (z_s_label),
    .total_cnt   (z_total_cnt),
    .correct_cnt (z_correct_cnt),
`endif
    .m_valid     (z_m_valid),
    .m_ready     (z_m_ready),
    .m_pred      (z_m_pred)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_word(input bit z, input logic [3:0] d, input logic [3:0] lbl);
    @(negedge clk);
    if (z) begin
      z_s_valid = 1'b1;
      z_s_data  = d;
`ifdef BNN_LOADER_STATS_EN
      z_s_label = lbl;
`endif
    end else begin
      s_valid = 1'b1;
      s_data  = d;
`ifdef BNN_LOADER_STATS_EN
      s_label = lbl;
`endif
    end
  endtask

  // Drops valid and scrambles data so a stray accept would be visible.
  task automatic idle(input bit z);
    @(negedge clk);
    if (z) begin
      z_s_valid = 1'b0;
      z_s_data  = ~z_s_data;
    end else begin
      s_valid = 1'b0;
      s_data  = ~s_data;
    end
  endtask

  // Word i = (mul*i + add) mod 16; returns at the negedge right after the last beat.
  task automatic send_vec(input bit z, input int mul, input int add, input logic [3:0] lbl,
                          input bit gaps);
    for (int i = 0; i < 16; i++) begin
      send_word(z, 4'((mul * i + add) & 15), lbl);
      if (gaps) idle(z);
    end
    if (!gaps) idle(z);
  endtask

  task automatic wait_valid(input bit z, output int c);
    c = 0;
    while (!(z ? z_m_valid : m_valid) && c < 50) begin
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_features", features, 64'h0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_pred", m_pred, 4'h0);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_idx", u_dut.u_deser.idx_q, 4'h0);
    rst_n = 1'b1;

    // Basic vector
    pred_in = 4'd7;
    m_ready = 1'b1;
    send_vec(1'b0, 1, 1, 4'd0, 1'b0);
    check("basic_features", features, 64'h0FEDCBA987654321);
    check("basic_s_ready_busy", s_ready, 1'b0);
    wait_valid(1'b0, cyc);
    check("basic_latency", cyc, 3);
    check("basic_m_pred", m_pred, 4'd7);
    @(negedge clk);
    check("basic_m_valid_drop", m_valid, 1'b0);
    check("basic_s_ready_back", s_ready, 1'b1);

    // Result backpressure
    pred_in = 4'd5;
    m_ready = 1'b0;
    send_vec(1'b0, 15, 15, 4'd0, 1'b0);
    wait_valid(1'b0, cyc);
    check("bp_latency", cyc, 3);
    check("bp_m_pred", m_pred, 4'd5);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_hold_valid", m_valid, 1'b1);
      check("bp_hold_pred", m_pred, 4'd5);
      check("bp_hold_s_ready", s_ready, 1'b0);
      if (k == 3) pred_in = 4'd2;
      if (k == 5) begin
        s_valid = 1'b1;
        s_data  = 4'h3;
      end
      if (k == 6) s_valid = 1'b0;
    end
    check("bp_features_frozen", features, 64'h0123456789ABCDEF);
    m_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", m_valid, 1'b0);
    check("bp_release_s_ready", s_ready, 1'b1);

    // Producer gaps
    pred_in = 4'd9;
    send_vec(1'b0, 3, 1, 4'd0, 1'b1);
    check("gap_features", features, 64'hEB852FC9630DA741);
    wait_valid(1'b0, cyc);
    check("gap_latency", cyc, 3);
    check("gap_m_pred", m_pred, 4'd9);
    @(negedge clk);

    // Reset mid-vector
    for (int i = 0; i < 5; i++) send_word(1'b0, 4'h5, 4'd0);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("mid_rst_features", features, 64'h0);
    check("mid_rst_idx", u_dut.u_deser.idx_q, 4'h0);
    check("mid_rst_m_valid", m_valid, 1'b0);
    check("mid_rst_s_ready", s_ready, 1'b1);
    @(negedge clk);
    rst_n   = 1'b1;
    pred_in = 4'd4;
    send_vec(1'b0, 1, 0, 4'd0, 1'b0);
    check("post_rst_features", features, 64'hFEDCBA9876543210);
    wait_valid(1'b0, cyc);
    check("post_rst_latency", cyc, 3);
    check("post_rst_m_pred", m_pred, 4'd4);
    @(negedge clk);
    check("post_rst_s_ready", s_ready, 1'b1);

`ifdef BNN_LOADER_STATS_EN
    // Stats: labels 3,3,5,3 against prediction 3
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("stats_rst_total", total_cnt, 16'd0);
    pred_in = 4'd3;
    for (int v = 0; v < 4; v++) begin
      send_vec(1'b0, 1, v, (v == 2) ? 4'd5 : 4'd3, 1'b0);
      wait_valid(1'b0, cyc);
      check("stats_latency", cyc, 3);
      @(negedge clk);
    end
    check("stats_total", total_cnt, 16'd4);
    check("stats_correct", correct_cnt, 16'd3);
`endif

    // No settle delay: prediction sampled on the edge after the last beat
    z_pred_in = 4'd6;
    z_m_ready = 1'b1;
    send_vec(1'b1, 0, 3, 4'd2, 1'b0);
    z_pred_in = 4'd2;
    check("z_features", z_features, 64'h3333333333333333);
    check("z_m_valid_early", z_m_valid, 1'b0);
    wait_valid(1'b1, cyc);
    check("z_latency", cyc, 1);
    check("z_m_pred", z_m_pred, 4'd2);
    @(negedge clk);
    check("z_m_valid_drop", z_m_valid, 1'b0);
    check("z_s_ready_back", z_s_ready, 1'b1);

`ifdef BNN_LOADER_STATS_EN
    // Two-bit counters saturate after the fourth result
    z_pred_in = 4'd3;
    for (int v = 0; v < 3; v++) begin
      send_vec(1'b1, 1, v, 4'd3, 1'b0);
      wait_valid(1'b1, cyc);
      check("z_stats_latency", cyc, 1);
      @(negedge clk);
    end
    check("z_total_sat", z_total_cnt, 2'd3);
    check("z_correct_sat", z_correct_cnt, 2'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
